// File: rtl/axis2axi4_wr.sv
// Stream-to-memory write engine: turns a (base, length) command plus an AXI4-Stream
// into AXI4 INCR write bursts, one burst outstanding at a time, never crossing 4 KB.
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | AW request for the next burst (AWVALID registered)
// DATA   | moving beats stream -> W, or padding after an early TLAST
// RESP   | waiting for the burst's B response
// DONE   | one-cycle completion, back to IDLE
module axis2axi4_wr #(
    parameter int ID_W      = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      len_beats,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [LEN_W-1:0]      beats_done,
    input  logic                  TVALID,
    output logic                  TREADY,
    input  logic [DATA_W-1:0]     TDATA,
    input  logic [DATA_W/8-1:0]   TKEEP,
    input  logic                  TLAST,
    output logic [ID_W-1:0]       AWID,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWLOCK,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic [3:0]            AWQOS,
    output logic [3:0]            AWREGION,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    input  logic [ID_W-1:0]       BID,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [8:0]        burst_cnt;
    logic              pad;
    logic              aw_valid;
    logic [12:0]       to4k;
    logic [LEN_W-1:0]  rem_lim;
    logic [LEN_W-1:0]  beats;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              unused_bid;

    assign unused_bid = ^BID;

    // Burst size: limited by what is left, the max burst, and the next 4 KB boundary.
    assign to4k    = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
    assign rem_lim = (remaining > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : remaining;
    assign beats   = (rem_lim > LEN_W'(to4k)) ? LEN_W'(to4k) : rem_lim;

    assign aw_hs = aw_valid && AWREADY;
    assign w_hs  = (state == S_DATA) && WVALID && WREADY;
    assign b_hs  = (state == S_RESP) && BVALID;

    assign AWID     = '0;
    assign AWVALID  = aw_valid;
    assign AWADDR   = addr;
    assign AWLEN    = 8'(beats - LEN_W'(1));
    assign AWSIZE   = 3'(SZ);
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'b0011;
    assign AWPROT   = 3'b000;
    assign AWQOS    = 4'b0000;
    assign AWREGION = 4'b0000;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (len_beats == '0) ? S_DONE : S_ADDR;
            S_ADDR: if (aw_hs) state_nxt = S_DATA;
            S_DATA: if (w_hs && WLAST) state_nxt = S_RESP;
            S_RESP: if (b_hs) state_nxt = (remaining != '0) ? S_ADDR : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        TREADY = 1'b0;
        WVALID = 1'b0;
        WDATA  = '0;
        WSTRB  = '0;
        BREADY = 1'b0;
        WLAST  = (state == S_DATA) && (burst_cnt == 9'd1);
        case (state)
            S_DATA: begin
                if (pad) begin
                    WVALID = 1'b1;
                end else begin
                    WVALID = TVALID;
                    TREADY = WREADY;
                    WDATA  = TDATA;
                    WSTRB  = TKEEP;
                end
            end
            S_RESP: BREADY = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= 2'b00;
            beats_done <= '0;
            addr       <= '0;
            remaining  <= '0;
            burst_cnt  <= '0;
            pad        <= 1'b0;
        end else begin
            aw_valid <= (state == S_ADDR) && !aw_hs;
            done     <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                busy       <= 1'b1;
                addr       <= base_addr & ~ADDR_W'(BYTES - 1);
                remaining  <= len_beats;
                status     <= 2'b00;
                beats_done <= '0;
                pad        <= 1'b0;
            end else if (state == S_DONE) begin
                busy <= 1'b0;
            end
            if (aw_hs) begin
                addr      <= addr + (ADDR_W'(beats) << SZ);
                burst_cnt <= 9'(beats);
            end
            if (w_hs) begin
                burst_cnt <= burst_cnt - 9'd1;
                remaining <= remaining - LEN_W'(1);
                if (!pad) begin
                    beats_done <= beats_done + LEN_W'(1);
                    // Early TLAST pads out the rest of the command; late TLAST is only flagged.
                    if (TLAST && remaining != LEN_W'(1)) begin
                        status[1] <= 1'b1;
                        pad       <= 1'b1;
                    end
                    if (!TLAST && remaining == LEN_W'(1)) begin
                        status[1] <= 1'b1;
                    end
                end
            end
            if (b_hs && BRESP != 2'b00) begin
                status[0] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis2axi4_wr.sv
// Directed bench for axis2axi4_wr: a stream source and AXI slave run in the background,
// the main sequence issues commands and checks bursts, W data, status and timing.
module tb_axis2axi4_wr;

    logic        ACLK;
    logic        ARESETn;
    logic        start;
    logic [31:0] base_addr;
    logic [23:0] len_beats;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [23:0] beats_done;
    logic        TVALID;
    logic        TREADY;
    logic [63:0] TDATA;
    logic [7:0]  TKEEP;
    logic        TLAST;
    logic [0:0]  AWID;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic [3:0]  AWQOS;
    logic [3:0]  AWREGION;
    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic [0:0]  BID;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;

    axis2axi4_wr dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .base_addr(base_addr),
        .len_beats(len_beats), .busy(busy), .done(done), .status(status),
        .beats_done(beats_done), .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA),
        .TKEEP(TKEEP), .TLAST(TLAST), .AWID(AWID), .AWVALID(AWVALID),
        .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWQOS(AWQOS), .AWREGION(AWREGION), .WVALID(WVALID), .WREADY(WREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .BID(BID), .BVALID(BVALID),
        .BREADY(BREADY), .BRESP(BRESP)
    );

    int          total = 0;
    int          bad = 0;
    int          s_idx = 0;
    int          tlast_at = 0;
    int          err_burst = 0;
    int          b_cnt = 0;
    int          b_pend = 0;
    int          aw_stab_err = 0;
    int          done_cyc = 0;
    bit          rnd = 0;
    bit          stream_en = 0;
    logic [15:0] tag = 16'h0;
    logic [1:0]  fin_status;
    logic [23:0] fin_beats;
    bit          t_hs_f, w_hs_f, wlast_f, b_hs_f, aw_wait;
    logic [31:0] aw_addr_s;
    logic [7:0]  aw_len_s;

    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [63:0] w_data_q[$];
    logic [7:0]  w_strb_q[$];
    bit          w_last_q[$];

    assign TDATA = {16'hC0DE, tag, 32'(s_idx)};
    assign TKEEP = 8'hFF;
    assign TLAST = (s_idx + 1 == tlast_at);

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    function automatic logic [63:0] data_of(input int i);
        return {16'hC0DE, tag, 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Stream source and AXI slave; inputs change at negedge, handshakes sampled 1 ns later.
    initial begin
        TVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = '0;
        t_hs_f = 0; w_hs_f = 0; wlast_f = 0; b_hs_f = 0; aw_wait = 0;
        aw_addr_s = '0; aw_len_s = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                t_hs_f = 0; w_hs_f = 0; wlast_f = 0; b_hs_f = 0; aw_wait = 0;
                b_pend = 0;
                TVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
            end else begin
                if (t_hs_f) s_idx = s_idx + 1;
                if (b_hs_f) begin b_pend = b_pend - 1; b_cnt = b_cnt + 1; end
                if (w_hs_f && wlast_f) b_pend = b_pend + 1;
                TVALID  = stream_en && ((TVALID && !t_hs_f) || !rnd || ($urandom_range(0, 3) != 0));
                AWREADY = !rnd || ($urandom_range(0, 1) == 1);
                WREADY  = !rnd || ($urandom_range(0, 3) != 0);
                BVALID  = (b_pend > 0) && ((BVALID && !b_hs_f) || !rnd || ($urandom_range(0, 1) == 1));
                BRESP   = (b_cnt + 1 == err_burst) ? 2'b10 : 2'b00;
            end
            #1;
            if (ARESETn) begin
                t_hs_f  = TVALID && TREADY;
                w_hs_f  = WVALID && WREADY;
                wlast_f = WLAST;
                b_hs_f  = BVALID && BREADY;
                if (AWVALID && AWREADY) begin
                    aw_addr_q.push_back(AWADDR);
                    aw_len_q.push_back(AWLEN);
                end
                if (w_hs_f) begin
                    w_data_q.push_back(WDATA);
                    w_strb_q.push_back(WSTRB);
                    w_last_q.push_back(WLAST);
                end
                if (aw_wait && AWVALID && (AWADDR !== aw_addr_s || AWLEN !== aw_len_s))
                    aw_stab_err++;
                aw_wait   = AWVALID && !AWREADY;
                aw_addr_s = AWADDR;
                aw_len_s  = AWLEN;
            end
        end
    end

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete();
        w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    endtask

    task automatic issue(input logic [31:0] base, input logic [23:0] len, input int tl,
                         input bit r, input int eb);
        @(negedge ACLK);
        clear_logs();
        s_idx = 0; tlast_at = tl; rnd = r; err_burst = eb; b_cnt = 0; aw_stab_err = 0;
        stream_en = 1; tag = tag + 16'h1;
        base_addr = base; len_beats = len; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic run_cmd(input logic [31:0] base, input logic [23:0] len, input int tl,
                           input bit r, input int eb, input int budget);
        int  n;
        bit  got;
        issue(base, len, tl, r, eb);
        n = 0; got = 0;
        while (n < budget && !got) begin
            if (done) got = 1;
            else begin @(negedge ACLK); n++; end
        end
        chk("done_seen", 64'(got), 64'(1));
        chk("busy_low_at_done", 64'(busy), 64'(0));
        done_cyc   = n + 1;
        fin_status = status;
        fin_beats  = beats_done;
        stream_en  = 0;
    endtask

    task automatic check_w(input int n, input int nreal, input int e1, input int e2, input int e3);
        chk("w_count", 64'(w_data_q.size()), 64'(n));
        if (w_data_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("wdata[%0d]", i), w_data_q[i], (i < nreal) ? data_of(i) : 64'h0);
                chk($sformatf("wstrb[%0d]", i), 64'(w_strb_q[i]), (i < nreal) ? 64'hFF : 64'h0);
                chk($sformatf("wlast[%0d]", i), 64'(w_last_q[i]),
                    64'((i + 1 == e1) || (i + 1 == e2) || (i + 1 == e3)));
            end
        end
    endtask

    task automatic check_case1(input string pfx);
        chk({pfx, "_aw_count"}, 64'(aw_addr_q.size()), 64'(3));
        if (aw_addr_q.size() == 3) begin
            chk({pfx, "_aw0"}, {aw_addr_q[0], 24'h0, aw_len_q[0]}, {32'h1000, 24'h0, 8'd15});
            chk({pfx, "_aw1"}, {aw_addr_q[1], 24'h0, aw_len_q[1]}, {32'h1080, 24'h0, 8'd15});
            chk({pfx, "_aw2"}, {aw_addr_q[2], 24'h0, aw_len_q[2]}, {32'h1100, 24'h0, 8'd7});
        end
        check_w(40, 40, 16, 32, 40);
        chk({pfx, "_status"}, 64'(fin_status), 64'(2'b00));
        chk({pfx, "_beats_done"}, 64'(fin_beats), 64'(40));
    endtask

    initial begin
        int n;
        ARESETn = 1'b0; start = 1'b0; base_addr = '0; len_beats = '0;
        repeat (3) @(negedge ACLK);
        chk("rst_ctl", 64'({busy, done, AWVALID, WVALID, TREADY, BREADY}), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_beats_done", 64'(beats_done), 64'(0));
        chk("aw_const", 64'({AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION}),
            64'({1'b0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0}));
        #3 ARESETn = 1'b1;

        // Case 1: 40 beats from 0x1000, all ready
        run_cmd(32'h1000, 24'd40, 40, 0, 0, 500);
        check_case1("c1");

        // Case 2: 4 KB boundary split
        run_cmd(32'h0FE0, 24'd8, 8, 0, 0, 300);
        chk("c2_aw_count", 64'(aw_addr_q.size()), 64'(2));
        if (aw_addr_q.size() == 2) begin
            chk("c2_aw0", {aw_addr_q[0], 24'h0, aw_len_q[0]}, {32'h0FE0, 24'h0, 8'd3});
            chk("c2_aw1", {aw_addr_q[1], 24'h0, aw_len_q[1]}, {32'h1000, 24'h0, 8'd3});
        end
        check_w(8, 8, 4, 8, 0);
        chk("c2_status", 64'(fin_status), 64'(0));

        // Case 3: case 1 with random backpressure everywhere
        run_cmd(32'h1000, 24'd40, 40, 1, 0, 3000);
        check_case1("c3");
        chk("c3_aw_stable", 64'(aw_stab_err), 64'(0));

        // Case 4: early TLAST on beat 5 of 16 -> padding
        run_cmd(32'h2000, 24'd16, 5, 0, 0, 300);
        chk("c4_aw_count", 64'(aw_addr_q.size()), 64'(1));
        check_w(16, 5, 16, 0, 0);
        chk("c4_stream_taken", 64'(s_idx), 64'(5));
        chk("c4_status", 64'(fin_status), 64'(2'b10));
        chk("c4_beats_done", 64'(fin_beats), 64'(5));

        // Case 5: SLVERR on burst 2 does not abort
        run_cmd(32'h1000, 24'd40, 40, 0, 2, 500);
        chk("c5_aw_count", 64'(aw_addr_q.size()), 64'(3));
        chk("c5_status", 64'(fin_status), 64'(2'b01));
        chk("c5_beats_done", 64'(fin_beats), 64'(40));

        // Case 6a: zero-length command
        run_cmd(32'h3000, 24'd0, 0, 0, 0, 20);
        chk("c6a_done_latency", 64'(done_cyc), 64'(2));
        chk("c6a_no_aw", 64'(aw_addr_q.size()), 64'(0));
        chk("c6a_status", 64'(fin_status), 64'(0));

        // Case 6b: reset in the middle of a burst, then a clean rerun
        issue(32'h1000, 24'd40, 40, 0, 0);
        n = 0;
        while (n < 200 && w_data_q.size() < 5) begin @(negedge ACLK); n++; end
        chk("c6b_in_data", 64'(w_data_q.size() >= 5), 64'(1));
        #3 ARESETn = 1'b0;
        #1;
        chk("c6b_rst_ctl", 64'({busy, AWVALID, WVALID, TREADY, BREADY}), 64'(0));
        chk("c6b_rst_status", 64'({status, beats_done}), 64'(0));
        stream_en = 0;
        repeat (2) @(negedge ACLK);
        #3 ARESETn = 1'b1;
        run_cmd(32'h1000, 24'd40, 40, 0, 0, 500);
        check_case1("c6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
